// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing one shifter_extender
// Optional feature macro: SHIFT_ARB_RR_EN (round-robin arbitration; fixed priority when undefined)
module shift_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in,
  input  logic [5:0]  req0_value,
  input  logic [2:0]  req0_t,
  input  logic        req0_e,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in,
  input  logic [5:0]  req1_value,
  input  logic [2:0]  req1_t,
  input  logic        req1_e,
  output logic [31:0] sh_in,
  output logic [5:0]  sh_value,
  output logic [2:0]  sh_t,
  output logic        sh_e,
  input  logic [31:0] sh_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_sel;
  logic        w_can_accept;
  logic        w_accept;
  logic        r_grant_id;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;
  logic [31:0] r_sh_in;
  logic [5:0]  r_sh_value;
  logic [2:0]  r_sh_t;
  logic        r_sh_e;

`ifdef SHIFT_ARB_RR_EN
  // Last granted requester; reset to 1 so requester 0 wins the first tie
  logic r_last_grant;

  // Pointer follows every acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_sel;
    end
  end

  // Round-robin winner: on a tie the requester not granted last time wins
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end
  end
`else
  // Fixed priority winner: requester 0 always wins a tie
  always_comb begin
    w_sel = 1'b0;
    if (req1_valid && !req0_valid) begin
      w_sel = 1'b1;
    end
  end
`endif

  // A new request may be taken in IDLE, or in RESP in the same cycle the result drains
  assign w_can_accept = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
  assign w_accept     = w_can_accept && (req0_valid || req1_valid);
  assign req0_ready   = w_can_accept && req0_valid && !w_sel;
  assign req1_ready   = w_can_accept && req1_valid && w_sel;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shifter controls latch only on acceptance; response captured in EXEC, held until drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_in     <= 32'd0;
      r_sh_value  <= 6'd0;
      r_sh_t      <= 3'd0;
      r_sh_e      <= 1'b0;
      r_grant_id  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_sh_in    <= w_sel ? req1_in    : req0_in;
        r_sh_value <= w_sel ? req1_value : req0_value;
        r_sh_t     <= w_sel ? req1_t     : req0_t;
        r_sh_e     <= w_sel ? req1_e     : req0_e;
        r_grant_id <= w_sel;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_grant_id;
        r_rsp_data  <= sh_out;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign sh_in     = r_sh_in;
  assign sh_value  = r_sh_value;
  assign sh_t      = r_sh_t;
  assign sh_e      = r_sh_e;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have no parameters; all datapath widths are fixed (32-bit data, 6-bit shift value, 3-bit type, 1-bit E).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0 (ALU operand2 path) / requester 1 (load-store address path) has an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle when ready and valid are both high.
REQ-006 reqN_in  input  32, reqN_value  input  6, reqN_t  input  3, reqN_e  input  1  operand, shift amount, type and E select per requester (N=0,1).
REQ-007 sh_in  output  32, sh_value  output  6, sh_t  output  3, sh_e  output  1  registered controls driving the shared shifter_extender.
REQ-008 sh_out  input  32  combinational result returned by the shared shifter_extender.
REQ-009 rsp_valid  output  1, rsp_id  output  1, rsp_data  output  32  result valid, owning requester, result value.
REQ-010 rsp_ready  input  1  consumer accepts the result when rsp_valid and rsp_ready are both high.

Function
REQ-011 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-012 IDLE: if any reqN_valid, the arbiter SHALL grant one requester, assert only its ready, latch its fields into sh_* and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-013 EXEC: the arbiter SHALL capture sh_out into rsp_data, set rsp_id to the granted requester, set rsp_valid=1 and go to RESP; no ready SHALL be asserted.
REQ-014 RESP: rsp_valid, rsp_id and rsp_data SHALL hold stable until rsp_ready=1.
REQ-015 RESP with rsp_ready=1 and any reqN_valid: the arbiter SHALL accept the granted request in the same cycle (ready asserted), clear rsp_valid and go to EXEC.
REQ-016 RESP with rsp_ready=1 and no reqN_valid: rsp_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-017 reqN_ready SHALL be combinational: high only when (state==IDLE or (state==RESP and rsp_ready)) and requester N wins arbitration and reqN_valid=1.
REQ-018 At most one reqN_ready SHALL be high in any cycle.
REQ-019 Latency SHALL be 2 cycles from acceptance to rsp_valid; peak throughput SHALL be one result per 2 cycles.
REQ-020 sh_* SHALL hold their last latched values while no new request is accepted.
REQ-021 sh_* fields SHALL be passed unmodified; undefined type codes (E=0 t=7, E=1 t=6/7) SHALL NOT be checked and the result SHALL be whatever sh_out returns.
REQ-022 A requester SHALL hold its valid and fields stable until accepted; the arbiter SHALL sample the fields only in the accepting cycle.

Reset
REQ-023 When reset_n=0, the arbiter SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, sh_in=0, sh_value=0, sh_t=0, sh_e=0 and the round-robin pointer to favour requester 0, independent of clk.
REQ-024 An operation accepted or pending in EXEC/RESP when reset asserts SHALL be discarded with no response.
REQ-025 After reset_n deasserts, the first acceptance SHALL occur no earlier than the first rising clk edge with reset_n=1.

Configuration
REQ-026 With SHIFT_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valids, the requester not granted most recently SHALL win; the pointer SHALL update on every acceptance.
REQ-027 Without SHIFT_ARB_RR_EN, arbitration SHALL be fixed priority, requester 0 always winning simultaneous valids; the pointer logic SHALL be absent.

Verification
REQ-028 Reset, then req0 in=0x00000001 value=4 t=0 e=0, rsp_ready=1 -> req0_ready in the IDLE cycle, rsp_valid 2 cycles later with rsp_id=0, rsp_data=0x00000010.
REQ-029 req1 in=0x00000080 t=0 e=1 -> rsp_id=1, rsp_data=0xFFFFFF80; sh_e=1 and sh_t=0 observed during EXEC.
REQ-030 Both valids held high continuously, rsp_ready=1 -> with SHIFT_ARB_RR_EN rsp_id sequence 0,1,0,1; without it 0,0,0,0, one result every 2 cycles.
REQ-031 rsp_ready=0 for 5 cycles in RESP with req0_valid=1 -> rsp_valid/rsp_data stable, req0_ready=0 throughout; raising rsp_ready accepts req0 in that same cycle.
REQ-032 reset_n pulsed low mid-EXEC -> rsp_valid=0 and all outputs zero immediately, no response for the aborted operation, next request served normally.
